// File: rtl/store_rmw_sequencer.sv
// Read-modify-write sequencer for sub-doubleword stores into a 64-bit data memory.
// SB/SH/SW read the doubleword, merge the store lanes and write back; SD writes directly.
module store_rmw_sequencer #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StoreValid,
    output logic              StoreReady,
    input  logic [ADDR_W-1:0] StoreAddr,
    input  logic [63:0]       StoreData,
    input  logic [1:0]        StoreType,
    output logic              StoreDone,
    output logic              StoreErr,
    output logic              Busy,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [63:0]       MemWData,
    input  logic [63:0]       MemRData,
    input  logic              MemAck
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        type_q, type_d;
    logic [2:0]        off_q, off_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              misaligned;
    logic              timeout_hit;
    logic [3:0]        nbytes;
    logic [2:0]        src;
    logic [63:0]       merged;

    assign StoreReady  = (state_q == StIdle) && !reset;
    assign Busy        = (state_q != StIdle);
    assign MemReq      = req_q;
    assign MemWe       = we_q;
    assign MemAddr     = addr_q;
    assign MemWData    = wdata_q;
    assign StoreDone   = done_q;
    assign StoreErr    = err_q;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);
    assign nbytes      = 4'd1 << type_q;

    always_comb begin
        case (StoreType)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = StoreAddr[0];
            2'd2:    misaligned = |StoreAddr[1:0];
            default: misaligned = |StoreAddr[2:0];
        endcase
    end

    // Replace lanes [off .. off+n-1] of the read doubleword with the low store bytes.
    always_comb begin
        merged = MemRData;
        src    = '0;
        for (int i = 0; i < 8; i++) begin
            src = 3'(i) - off_q;
            if ((4'(i) >= {1'b0, off_q}) && (4'(i) < ({1'b0, off_q} + nbytes))) begin
                merged[8*i +: 8] = data_q[8*src[1:0] +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        type_d  = type_q;
        off_d   = off_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (StoreValid && StoreReady) begin
                    if (misaligned) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        addr_d = {StoreAddr[ADDR_W-1:3], 3'b000};
                        data_d = StoreData[31:0];
                        type_d = StoreType;
                        off_d  = StoreAddr[2:0];
                        cnt_d  = '0;
                        if (StoreType == 2'd3) begin
                            wdata_d = StoreData;
                            state_d = StWrite;
                        end else begin
                            state_d = StRead;
                        end
                    end
                end
            end
            StRead: begin
                if (MemAck) begin
                    wdata_d = merged;
                    cnt_d   = '0;
                    state_d = StWrite;
                end else if (timeout_hit) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWrite: begin
                if (MemAck) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        req_d = (state_d != StIdle);
        we_d  = (state_d == StWrite);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            type_q  <= '0;
            off_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            type_q  <= type_d;
            off_q   <= off_d;
            req_q   <= req_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Self-checking bench: directed scenarios plus random stores against a doubleword memory model.
module tb_store_rmw_sequencer;

    localparam int unsigned AW = 64;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          StoreValid;
    logic          StoreReady;
    logic [AW-1:0] StoreAddr;
    logic [63:0]   StoreData;
    logic [1:0]    StoreType;
    logic          StoreDone;
    logic          StoreErr;
    logic          Busy;
    logic          MemReq;
    logic          MemWe;
    logic [AW-1:0] MemAddr;
    logic [63:0]   MemWData;
    logic [63:0]   MemRData;
    logic          MemAck;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [63:0] mem [logic [63:0]];

    always #5 clk = ~clk;

    store_rmw_sequencer #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .StoreValid (StoreValid),
        .StoreReady (StoreReady),
        .StoreAddr  (StoreAddr),
        .StoreData  (StoreData),
        .StoreType  (StoreType),
        .StoreDone  (StoreDone),
        .StoreErr   (StoreErr),
        .Busy       (Busy),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemRData   (MemRData),
        .MemAck     (MemAck)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd_mem(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] typ, input logic [2:0] off);
        int unsigned size = 1 << typ;
        return (off % size) != 0;
    endfunction

    function automatic logic [63:0] merge_ref(input logic [63:0] old, input logic [63:0] data,
                                              input logic [1:0] typ, input logic [2:0] off);
        logic [63:0] mask;
        if (typ == 2'd3) return data;
        mask = (64'd1 << (8 * (1 << typ))) - 64'd1;
        return (old & ~(mask << (8 * off))) | ((data & mask) << (8 * off));
    endfunction

    // One memory request lasting w wait cycles plus the acked cycle.
    task automatic phase(input logic we, input logic [63:0] da, input logic [63:0] wd,
                         input int w);
        for (int k = 0; k <= w; k++) begin
            check("mem_req", 64'(MemReq), 64'd1);
            check("mem_we", 64'(MemWe), 64'(we));
            check("mem_addr", MemAddr, da);
            if (we) check("mem_wdata", MemWData, wd);
            check("busy", 64'(Busy), 64'd1);
            check("done_early", 64'(StoreDone), 64'd0);
            MemRData = (k == w) ? rd_mem(da) : {$urandom, $urandom};
            MemAck   = (k == w);
            @(posedge clk); #1;
            MemAck = 1'b0;
        end
    endtask

    task automatic accept(input logic [1:0] typ, input logic [63:0] addr, input logic [63:0] data);
        check("ready", 64'(StoreReady), 64'd1);
        StoreValid = 1'b1;
        StoreType  = typ;
        StoreAddr  = addr;
        StoreData  = data;
        @(posedge clk); #1;
        StoreValid = 1'b0;
        StoreAddr  = {$urandom, $urandom};
        StoreData  = {$urandom, $urandom};
    endtask

    task automatic run_store(input logic [1:0] typ, input logic [63:0] addr,
                             input logic [63:0] data, input int rw, input int ww);
        logic [63:0] da;
        logic [63:0] exp;
        da = {addr[63:3], 3'b000};
        accept(typ, addr, data);
        if (is_misaligned(typ, addr[2:0])) begin
            check("mis_done", 64'(StoreDone), 64'd1);
            check("mis_err", 64'(StoreErr), 64'd1);
            check("mis_req", 64'(MemReq), 64'd0);
            check("mis_busy", 64'(Busy), 64'd0);
            return;
        end
        if (typ != 2'd3) phase(1'b0, da, 64'd0, rw);
        exp = merge_ref(rd_mem(da), data, typ, addr[2:0]);
        phase(1'b1, da, exp, ww);
        mem[da] = exp;
        check("done", 64'(StoreDone), 64'd1);
        check("err", 64'(StoreErr), 64'd0);
        check("req_after", 64'(MemReq), 64'd0);
        check("busy_after", 64'(Busy), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        StoreValid = 1'b0;
        StoreAddr  = '0;
        StoreData  = '0;
        StoreType  = '0;
        MemRData   = '0;
        MemAck     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(StoreReady), 64'd0);
        check("rst_req", 64'(MemReq), 64'd0);
        check("rst_we", 64'(MemWe), 64'd0);
        check("rst_addr", MemAddr, 64'd0);
        check("rst_wdata", MemWData, 64'd0);
        check("rst_done", 64'(StoreDone), 64'd0);
        check("rst_err", 64'(StoreErr), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        reset = 1'b0;
        #1;
        check("ready_out_of_reset", 64'(StoreReady), 64'd1);

        run_store(2'd3, 64'h1000, 64'h1122334455667788, 0, 0);
        mem[64'h1000] = 64'hFFEEDDCCBBAA9988;
        run_store(2'd0, 64'h1005, 64'hAB, 0, 0);
        check("sb_mem", mem[64'h1000], 64'hFFEEABCCBBAA9988);
        mem[64'h2000] = 64'd0;
        run_store(2'd2, 64'h2004, 64'hDEADBEEF, 3, 0);
        run_store(2'd1, 64'h3003, 64'h1234, 0, 0);
        run_store(2'd3, 64'h3008, 64'h0F0E0D0C0B0A0908, 0, 0);
        // Ack on the last cycle before the watchdog would fire.
        run_store(2'd2, 64'h3010, 64'hCAFEF00D, TO - 1, TO - 1);

        accept(2'd0, 64'h4001, 64'h55);
        for (int k = 0; k < int'(TO); k++) begin
            check("to_req", 64'(MemReq), 64'd1);
            check("to_we", 64'(MemWe), 64'd0);
            @(posedge clk); #1;
        end
        check("to_req_low", 64'(MemReq), 64'd0);
        check("to_done", 64'(StoreDone), 64'd1);
        check("to_err", 64'(StoreErr), 64'd1);
        @(posedge clk); #1;
        check("to_no_write", 64'(MemReq), 64'd0);

        accept(2'd3, 64'h5000, 64'h0123456789ABCDEF);
        repeat (2) begin
            check("rst_wait_req", 64'(MemReq), 64'd1);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        check("rst_mid_ready", 64'(StoreReady), 64'd0);
        @(posedge clk); #1;
        check("rst_mid_req", 64'(MemReq), 64'd0);
        check("rst_mid_busy", 64'(Busy), 64'd0);
        check("rst_mid_done", 64'(StoreDone), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_done2", 64'(StoreDone), 64'd0);
        run_store(2'd0, 64'h5003, 64'h7E, 1, 1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                MemAck = $urandom_range(0, 1) != 0;
                @(posedge clk); #1;
                MemAck = 1'b0;
                check("idle_req", 64'(MemReq), 64'd0);
                check("idle_done", 64'(StoreDone), 64'd0);
            end
            run_store(2'($urandom_range(0, 3)), 64'h1000 + 64'($urandom_range(0, 31)),
                      {$urandom, $urandom}, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
